// File: rtl/proc_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : proc_pkg
//  Brief    : Shared opcode, PC-command and control-state encodings used by
//             pc_control, return_stack and pc_counter.
//  Revision : 1.0
// ============================================================================
package proc_pkg;

   // Control opcodes of the instruction at the current PC (111 is reserved, acts as NOP)
   localparam logic [2:0] OP_NOP  = 3'b000;
   localparam logic [2:0] OP_JMP  = 3'b001;
   localparam logic [2:0] OP_BZ   = 3'b010;
   localparam logic [2:0] OP_BNZ  = 3'b011;
   localparam logic [2:0] OP_CALL = 3'b100;
   localparam logic [2:0] OP_RET  = 3'b101;
   localparam logic [2:0] OP_HALT = 3'b110;

   // PC update commands understood by pc_counter (10 is never produced)
   localparam logic [1:0] PC_INC  = 2'b00;
   localparam logic [1:0] PC_LOAD = 2'b01;
   localparam logic [1:0] PC_HOLD = 2'b11;

   // Control state encoding
   localparam logic [1:0] ST_RUN   = 2'b00;
   localparam logic [1:0] ST_HALT  = 2'b01;
   localparam logic [1:0] ST_FAULT = 2'b10;

endpackage : proc_pkg
`default_nettype wire

// File: rtl/return_stack.sv
`default_nettype none
// ============================================================================
//  Module   : return_stack
//  Brief    : Register-file LIFO holding CALL return addresses. Writes are
//             synchronous; the top entry is read combinationally. Only the
//             occupancy counter is reset, entry contents are don't-care.
//  Revision : 1.0
// ============================================================================
module return_stack #(
   parameter int DEPTH = 8,
   parameter int AW    = 10
) (
   input  logic                     clock,
   input  logic                     reset_n,
   input  logic                     push,
   input  logic                     pop,
   input  logic [AW-1:0]            push_data,
   output logic [AW-1:0]            top,
   output logic [$clog2(DEPTH):0]   sp,
   output logic                     full,
   output logic                     empty
);

   localparam int IW  = $clog2(DEPTH);
   localparam int SPW = IW + 1;

   logic [AW-1:0]  mem_q [DEPTH];
   logic [SPW-1:0] sp_q;
   logic [SPW-1:0] sp_d;

   assign full  = (sp_q == SPW'(DEPTH));
   assign empty = (sp_q == '0);
   assign sp    = sp_q;
   // With sp = 0 this reads the last slot; callers never use top when empty.
   assign top   = mem_q[sp_q[IW-1:0] - IW'(1)];

   // Occupancy next-state: guarded push/pop, a simultaneous request is ignored
   always_comb begin
      sp_d = sp_q;
      if (push && !pop && !full) begin
         sp_d = sp_q + SPW'(1);
      end else if (pop && !push && !empty) begin
         sp_d = sp_q - SPW'(1);
      end
   end

   // Occupancy register, asynchronously cleared
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         sp_q <= '0;
      end else begin
         sp_q <= sp_d;
      end
   end

   // Entry storage: write the slot just above the current top on push
   always_ff @(posedge clock) begin
      if (push && !pop && !full) begin
         mem_q[sp_q[IW-1:0]] <= push_data;
      end
   end

endmodule : return_stack
`default_nettype wire

// File: rtl/pc_control.sv
`default_nettype none
// ============================================================================
//  Module   : pc_control
//  Brief    : Next-PC control unit. Decodes the control opcode of the current
//             instruction into a PC command/target for pc_counter, manages a
//             hardware return-address stack and a RUN/HALT/FAULT state machine.
//  Revision : 1.0
// ============================================================================
module pc_control #(
   parameter int DEPTH = 8,
   parameter int AW    = 10
) (
   input  logic                     clock,
   input  logic                     reset_n,
   input  logic [2:0]               op,
   input  logic [AW-1:0]            target,
   input  logic                     zero,
   input  logic [AW-1:0]            add_inst,
   input  logic                     stall,
   input  logic                     resume,
   output logic [1:0]               flag,
   output logic [AW-1:0]            new_add_inst,
   output logic                     halted,
   output logic                     fault,
   output logic [$clog2(DEPTH):0]   sp
);

   import proc_pkg::*;

   logic [1:0]    state_q;
   logic [1:0]    state_d;
   logic          push;
   logic          pop;
   logic [AW-1:0] stk_top;
   logic          stk_full;
   logic          stk_empty;

   return_stack #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_stack (
      .clock     (clock),
      .reset_n   (reset_n),
      .push      (push),
      .pop       (pop),
      .push_data (add_inst + AW'(1)),
      .top       (stk_top),
      .sp        (sp),
      .full      (stk_full),
      .empty     (stk_empty)
   );

   assign halted = (state_q == ST_HALT);
   assign fault  = (state_q == ST_FAULT);

   // Opcode decode, next-PC mux, stack requests and next state
   always_comb begin
      flag         = PC_HOLD;
      new_add_inst = '0;
      state_d      = state_q;
      push         = 1'b0;
      pop          = 1'b0;
      case (state_q)
         ST_RUN: begin
            if (!stall) begin
               case (op)
                  OP_JMP: begin
                     flag         = PC_LOAD;
                     new_add_inst = target;
                  end
                  OP_BZ: begin
                     flag         = zero ? PC_LOAD : PC_INC;
                     new_add_inst = zero ? target : '0;
                  end
                  OP_BNZ: begin
                     flag         = zero ? PC_INC : PC_LOAD;
                     new_add_inst = zero ? '0 : target;
                  end
                  OP_CALL: begin
                     if (stk_full) begin
                        state_d = ST_FAULT;
                     end else begin
                        flag         = PC_LOAD;
                        new_add_inst = target;
                        push         = 1'b1;
                     end
                  end
                  OP_RET: begin
                     if (stk_empty) begin
                        state_d = ST_FAULT;
                     end else begin
                        flag         = PC_LOAD;
                        new_add_inst = stk_top;
                        pop          = 1'b1;
                     end
                  end
                  OP_HALT: begin
                     state_d = ST_HALT;
                  end
                  default: begin
                     flag = PC_INC;
                  end
               endcase
            end
         end
         ST_HALT: begin
            // Resume steps past the HALT instruction itself
            if (resume) begin
               flag    = PC_INC;
               state_d = ST_RUN;
            end
         end
         default: begin
            // FAULT is sticky: hold the PC until reset
            state_d = ST_FAULT;
         end
      endcase
      // While reset is asserted the PC must hold regardless of decode
      if (!reset_n) begin
         flag         = PC_HOLD;
         new_add_inst = '0;
      end
   end

   // Control state register
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_RUN;
      end else begin
         state_q <= state_d;
      end
   end

endmodule : pc_control
`default_nettype wire

// File: tb/tb_pc_control.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pc_control
//  Brief    : Directed self-checking bench for pc_control.
//  Revision : 1.0
// ============================================================================
module tb_pc_control;

   localparam int DEPTH = 8;
   localparam int AW    = 10;

   logic          clock;
   logic          reset_n;
   logic [2:0]    op;
   logic [AW-1:0] target;
   logic          zero;
   logic [AW-1:0] add_inst;
   logic          stall;
   logic          resume;
   logic [1:0]    flag;
   logic [AW-1:0] new_add_inst;
   logic          halted;
   logic          fault;
   logic [3:0]    sp;

   int n_tests = 0;
   int n_fail  = 0;

   pc_control #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) dut (
      .clock        (clock),
      .reset_n      (reset_n),
      .op           (op),
      .target       (target),
      .zero         (zero),
      .add_inst     (add_inst),
      .stall        (stall),
      .resume       (resume),
      .flag         (flag),
      .new_add_inst (new_add_inst),
      .halted       (halted),
      .fault        (fault),
      .sp           (sp)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Advance to just after the next rising edge, where inputs are driven
   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // Settle point for sampling combinational outputs, away from the edge
   task automatic settle();
      @(negedge clock);
   endtask

   task automatic do_reset();
      reset_n  = 1'b0;
      op       = 3'b000;
      target   = '0;
      zero     = 1'b0;
      add_inst = '0;
      stall    = 1'b0;
      resume   = 1'b0;
      #1;
      settle();
      reset_n = 1'b1;
      tick();
   endtask

   task automatic test_reset();
      reset_n = 1'b0; op = 3'b000; target = '0; zero = 1'b0;
      add_inst = '0; stall = 1'b0; resume = 1'b0;
      #2;
      n_tests++;
      if (flag !== 2'b11 || new_add_inst !== '0 || halted !== 1'b0 || fault !== 1'b0 || sp !== 4'd0) begin
         n_fail++;
         $display("FAIL reset_state flag=%b nai=%h halted=%b fault=%b sp=%0d want 11/000/0/0/0", flag, new_add_inst, halted, fault, sp);
      end
      settle();
      reset_n = 1'b1;
      tick();
      for (int i = 0; i < 3; i++) begin
         op = 3'b000; add_inst = AW'(i);
         settle();
         n_tests++;
         if (flag !== 2'b00 || sp !== 4'd0) begin
            n_fail++;
            $display("FAIL nop_run[%0d] flag=%b sp=%0d want 00/0", i, flag, sp);
         end
         tick();
      end
      reset_n = 1'b0;
      #1;
      n_tests++;
      if (flag !== 2'b11) begin
         n_fail++;
         $display("FAIL reset_midrun flag=%b want 11", flag);
      end
      settle();
      reset_n = 1'b1;
      tick();
   endtask

   task automatic test_branch();
      logic [1:0] exp_f [4] = '{2'b01, 2'b00, 2'b00, 2'b01};
      logic [9:0] exp_a [4] = '{10'h155, 10'h000, 10'h000, 10'h155};
      logic [2:0] ops   [4] = '{3'b010, 3'b010, 3'b011, 3'b011};
      logic       zs    [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
      do_reset();
      for (int i = 0; i < 4; i++) begin
         op = ops[i]; zero = zs[i]; target = 10'h155; add_inst = 10'h040;
         settle();
         n_tests++;
         if (flag !== exp_f[i] || new_add_inst !== exp_a[i]) begin
            n_fail++;
            $display("FAIL branch[%0d] flag=%b nai=%h want %b/%h", i, flag, new_add_inst, exp_f[i], exp_a[i]);
         end
         tick();
      end
   endtask

   task automatic test_back_to_back();
      do_reset();
      op = 3'b100; add_inst = 10'h010; target = 10'h200;
      settle();
      n_tests++;
      if (flag !== 2'b01 || new_add_inst !== 10'h200) begin
         n_fail++;
         $display("FAIL call1 flag=%b nai=%h want 01/200", flag, new_add_inst);
      end
      tick();
      op = 3'b100; add_inst = 10'h200; target = 10'h300;
      settle();
      n_tests++;
      if (sp !== 4'd1 || new_add_inst !== 10'h300) begin
         n_fail++;
         $display("FAIL call2 sp=%0d nai=%h want 1/300", sp, new_add_inst);
      end
      tick();
      op = 3'b101; add_inst = 10'h300;
      settle();
      n_tests++;
      if (flag !== 2'b01 || new_add_inst !== 10'h201 || sp !== 4'd2) begin
         n_fail++;
         $display("FAIL ret1 flag=%b nai=%h sp=%0d want 01/201/2", flag, new_add_inst, sp);
      end
      tick();
      add_inst = 10'h201;
      settle();
      n_tests++;
      if (sp !== 4'd1 || new_add_inst !== 10'h011) begin
         n_fail++;
         $display("FAIL ret2 sp=%0d nai=%h want 1/011", sp, new_add_inst);
      end
      tick();
      op = 3'b000;
      settle();
      n_tests++;
      if (sp !== 4'd0 || flag !== 2'b00) begin
         n_fail++;
         $display("FAIL ret_done sp=%0d flag=%b want 0/00", sp, flag);
      end
      tick();
   endtask

   task automatic test_overflow();
      do_reset();
      for (int i = 0; i < 8; i++) begin
         op = 3'b100; add_inst = AW'(i * 16); target = AW'(i * 16 + 16);
         settle();
         n_tests++;
         if (flag !== 2'b01 || sp !== 4'(i)) begin
            n_fail++;
            $display("FAIL call_fill[%0d] flag=%b sp=%0d want 01/%0d", i, flag, sp, i);
         end
         tick();
      end
      op = 3'b100; add_inst = 10'h080; target = 10'h090;
      settle();
      n_tests++;
      if (flag !== 2'b11 || sp !== 4'd8 || new_add_inst !== '0) begin
         n_fail++;
         $display("FAIL call_full flag=%b sp=%0d nai=%h want 11/8/000", flag, sp, new_add_inst);
      end
      tick();
      for (int i = 0; i < 3; i++) begin
         op = (i == 0) ? 3'b101 : 3'b001; target = 10'h123; resume = 1'b1;
         settle();
         n_tests++;
         if (fault !== 1'b1 || flag !== 2'b11 || sp !== 4'd8) begin
            n_fail++;
            $display("FAIL fault_sticky[%0d] fault=%b flag=%b sp=%0d want 1/11/8", i, fault, flag, sp);
         end
         tick();
      end
      resume = 1'b0;
   endtask

   task automatic test_underflow_wrap();
      do_reset();
      op = 3'b101;
      settle();
      n_tests++;
      if (flag !== 2'b11) begin
         n_fail++;
         $display("FAIL ret_empty flag=%b want 11", flag);
      end
      tick();
      op = 3'b000;
      settle();
      n_tests++;
      if (fault !== 1'b1 || flag !== 2'b11) begin
         n_fail++;
         $display("FAIL ret_empty_fault fault=%b flag=%b want 1/11", fault, flag);
      end
      do_reset();
      op = 3'b100; add_inst = 10'h3FF; target = 10'h100;
      tick();
      op = 3'b101; add_inst = 10'h100;
      settle();
      n_tests++;
      if (flag !== 2'b01 || new_add_inst !== 10'h000) begin
         n_fail++;
         $display("FAIL ret_wrap flag=%b nai=%h want 01/000", flag, new_add_inst);
      end
      tick();
   endtask

   task automatic test_halt_stall();
      do_reset();
      op = 3'b110;
      settle();
      n_tests++;
      if (flag !== 2'b11 || halted !== 1'b0) begin
         n_fail++;
         $display("FAIL halt_op flag=%b halted=%b want 11/0", flag, halted);
      end
      tick();
      op = 3'b001; target = 10'h222;
      for (int i = 0; i < 5; i++) begin
         settle();
         n_tests++;
         if (halted !== 1'b1 || flag !== 2'b11) begin
            n_fail++;
            $display("FAIL halted[%0d] halted=%b flag=%b want 1/11", i, halted, flag);
         end
         tick();
      end
      resume = 1'b1; stall = 1'b1;
      settle();
      n_tests++;
      if (flag !== 2'b00 || new_add_inst !== '0) begin
         n_fail++;
         $display("FAIL resume flag=%b nai=%h want 00/000", flag, new_add_inst);
      end
      tick();
      resume = 1'b0; stall = 1'b0; op = 3'b000;
      settle();
      n_tests++;
      if (halted !== 1'b0 || flag !== 2'b00) begin
         n_fail++;
         $display("FAIL after_resume halted=%b flag=%b want 0/00", halted, flag);
      end
      tick();
      stall = 1'b1; op = 3'b001; target = 10'h123;
      settle();
      n_tests++;
      if (flag !== 2'b11 || new_add_inst !== '0) begin
         n_fail++;
         $display("FAIL stall_jmp flag=%b nai=%h want 11/000", flag, new_add_inst);
      end
      tick();
      op = 3'b100; add_inst = 10'h050;
      tick();
      stall = 1'b0; op = 3'b001;
      settle();
      n_tests++;
      if (sp !== 4'd0 || halted !== 1'b0 || fault !== 1'b0 || flag !== 2'b01 || new_add_inst !== 10'h123) begin
         n_fail++;
         $display("FAIL stall_nochange sp=%0d h=%b f=%b flag=%b nai=%h want 0/0/0/01/123", sp, halted, fault, flag, new_add_inst);
      end
      tick();
   endtask

   initial begin
      test_reset();
      test_branch();
      test_back_to_back();
      test_overflow();
      test_underflow_wrap();
      test_halt_stall();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule : tb_pc_control
`default_nettype wire
